// File: rtl/booth_mac_ctrl.sv
// Sequencer and burst accumulator around a 16x16 sequential Booth multiplier.
// Issues one multiply per accepted operand pair and reports the signed sum of each burst.
module booth_mac_ctrl #(
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    input  logic             in_last,
    output logic             mul_start,
    output logic [15:0]      mul_x,
    output logic [15:0]      mul_y,
    input  logic             mul_busy,
    input  logic [31:0]      mul_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             err_timeout
);

    localparam int unsigned PROD_W = 32;
    localparam int unsigned WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        ACCUM,
        OUTPUT
    } state_t;

    state_t                    state;
    logic [WD_W-1:0]           wd;
    logic signed [PROD_W-1:0]  prod;
    logic                      last_r;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          count;
    logic                      ovf;

    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum;
    logic                      ovf_next;
    logic [CNT_W-1:0]          count_next;

    // Start must coincide with the ISSUE cycle in which the multiplier is seen idle.
    assign mul_start = (state == ISSUE) && !mul_busy;

    // Next accumulator, sticky signed-overflow and saturating product count.
    always_comb begin
        prod_ext   = ACC_W'(prod);
        sum        = acc + prod_ext;
        ovf_next   = ovf | ((acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                            (sum[ACC_W-1] != acc[ACC_W-1]));
        count_next = (&count) ? count : count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            mul_x       <= '0;
            mul_y       <= '0;
            out_valid   <= 1'b0;
            out_acc     <= '0;
            out_count   <= '0;
            out_ovf     <= 1'b0;
            err_timeout <= 1'b0;
            wd          <= '0;
            prod        <= '0;
            last_r      <= 1'b0;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        mul_x    <= in_x;
                        mul_y    <= in_y;
                        last_r   <= in_last;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A multiply still running from before reset holds us here.
                    if (!mul_busy) begin
                        wd    <= '0;
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (mul_busy) begin
                        wd    <= '0;
                        state <= WAIT_LO;
                    end else if (wd == WD_MAX) begin
                        err_timeout <= 1'b1;
                        prod        <= '0;
                        state       <= ACCUM;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!mul_busy) begin
                        prod  <= mul_z;
                        state <= ACCUM;
                    end else if (wd == WD_MAX) begin
                        err_timeout <= 1'b1;
                        prod        <= '0;
                        state       <= ACCUM;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ACCUM: begin
                    acc   <= sum;
                    count <= count_next;
                    ovf   <= ovf_next;
                    if (last_r) begin
                        out_acc   <= sum;
                        out_count <= count_next;
                        out_ovf   <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Bench for booth_mac_ctrl: 40-bit and 32-bit accumulator instances run in lockstep
// against a behavioural multiplier and an arithmetic burst-sum reference.
module tb_booth_mac_ctrl;

    localparam int unsigned TIMEOUT = 63;
    localparam logic [63:0] MASK40 = 64'h0000_00FF_FFFF_FFFF;
    localparam logic [63:0] MASK32 = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_last;
    logic        mul_busy;
    logic [31:0] mul_z;
    logic        out_ready;

    logic        a_in_ready, a_mul_start, a_out_valid, a_out_ovf, a_err;
    logic [15:0] a_mul_x, a_mul_y;
    logic [39:0] a_out_acc;
    logic [7:0]  a_out_count;
    logic        b_in_ready, b_mul_start, b_out_valid, b_out_ovf, b_err;
    logic [15:0] b_mul_x, b_mul_y;
    logic [31:0] b_out_acc;
    logic [7:0]  b_out_count;

    int     errors = 0;
    int     checks = 0;
    int     starts = 0;
    int     mul_lat = 17;
    bit     mul_dead = 1'b0;
    longint acc40, acc32;
    bit     ovf40, ovf32;
    int     cnt;
    bit     exp_err;

    booth_mac_ctrl dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last), .mul_start(a_mul_start),
        .mul_x(a_mul_x), .mul_y(a_mul_y), .mul_busy(mul_busy), .mul_z(mul_z),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc),
        .out_count(a_out_count), .out_ovf(a_out_ovf), .err_timeout(a_err)
    );

    booth_mac_ctrl #(.ACC_W(32)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last), .mul_start(b_mul_start),
        .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_busy(mul_busy), .mul_z(mul_z),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc),
        .out_count(b_out_count), .out_ovf(b_out_ovf), .err_timeout(b_err)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: busy one cycle after start, product on busy fall.
    initial begin : mul_model
        bit go;
        int a, b;
        go = 1'b0;
        mul_busy = 1'b0;
        mul_z = '0;
        forever begin
            if (!go) begin
                @(negedge clk);
                #1;
                go = a_mul_start;
            end
            if (go) begin
                go = 1'b0;
                starts++;
                a = int'($signed(a_mul_x));
                b = int'($signed(a_mul_y));
                if (!mul_dead) begin
                    @(negedge clk);
                    mul_busy = 1'b1;
                    repeat (mul_lat - 1) @(negedge clk);
                    mul_z = 32'(a * b);
                    mul_busy = 1'b0;
                    #1;
                    go = a_mul_start;
                end
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    task automatic model_clear();
        acc40 = 0; acc32 = 0; ovf40 = 1'b0; ovf32 = 1'b0; cnt = 0;
    endtask

    // Signed overflow = the exact sum differs from its wrapped value.
    task automatic model_add(input longint p);
        longint t;
        t = acc40 + p;
        if (t != wrap(t, 40)) ovf40 = 1'b1;
        acc40 = wrap(t, 40);
        t = acc32 + p;
        if (t != wrap(t, 32)) ovf32 = 1'b1;
        acc32 = wrap(t, 32);
        cnt++;
    endtask

    task automatic send(input int x, input int y, input bit last, input string tag);
        int n;
        longint p;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 64'(a_in_ready & b_in_ready), 64'(1));
        chk({tag, "_no_early_valid"}, 64'(a_out_valid | b_out_valid), 64'(0));
        in_x = 16'(x);
        in_y = 16'(y);
        in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        p = mul_dead ? 64'sd0 : longint'(x) * longint'(y);
        model_add(p);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!a_out_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic get_result(input string tag);
        int ec;
        ec = (cnt > 255) ? 255 : cnt;
        wait_valid();
        chk({tag, "_valid"}, 64'(a_out_valid & b_out_valid), 64'(1));
        chk({tag, "_acc40"}, 64'(a_out_acc), 64'(acc40) & MASK40);
        chk({tag, "_acc32"}, 64'(b_out_acc), 64'(acc32) & MASK32);
        chk({tag, "_cnt_a"}, 64'(a_out_count), 64'(ec));
        chk({tag, "_cnt_b"}, 64'(b_out_count), 64'(ec));
        chk({tag, "_ovf40"}, 64'(a_out_ovf), 64'(ovf40));
        chk({tag, "_ovf32"}, 64'(b_out_ovf), 64'(ovf32));
        chk({tag, "_err"}, 64'({a_err, b_err}), exp_err ? 64'(3) : 64'(0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_released"}, 64'(a_out_valid | b_out_valid), 64'(0));
        model_clear();
    endtask

    initial begin : stimulus
        int s0, n, bad, len, stall;
        logic [39:0] hold_acc;

        rst = 1'b1;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0; out_ready = 1'b0;
        exp_err = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(a_in_ready | b_in_ready), 64'(0));
        chk("rst_mul_start", 64'(a_mul_start), 64'(0));
        chk("rst_mul_xy", 64'({a_mul_x, a_mul_y}), 64'(0));
        chk("rst_out_valid", 64'(a_out_valid | b_out_valid), 64'(0));
        chk("rst_out_acc", 64'({a_out_acc, b_out_acc}), 64'(0));
        chk("rst_out_cnt_ovf_err", 64'({a_out_count, a_out_ovf, a_err}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(a_in_ready), 64'(1));

        // Single product: -15, exactly one start pulse.
        s0 = starts;
        send(3, -5, 1'b1, "single");
        get_result("single");
        chk("single_starts", 64'(starts - s0), 64'(1));

        // Four-product burst, 2147436013.
        send(100, 200, 1'b0, "burst");
        send(-300, 7, 1'b0, "burst");
        send(32767, 32767, 1'b0, "burst");
        send(-32768, -32768, 1'b1, "burst");
        get_result("burst");

        // 32-bit instance overflows to 0x8000_0000; next burst starts clean.
        send(-32768, -32768, 1'b0, "ovf");
        send(-32768, -32768, 1'b1, "ovf");
        get_result("ovf");
        send(1, 1, 1'b1, "ovf_clear");
        get_result("ovf_clear");

        // Result held under back-pressure while in_valid pulses are ignored.
        send(11, -13, 1'b1, "hold");
        wait_valid();
        hold_acc = a_out_acc;
        bad = 0;
        s0 = starts;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_x = 16'(i);
            in_y = 16'(i + 1);
            in_last = 1'b1;
            @(negedge clk);
            if (!a_out_valid || a_out_acc !== hold_acc || a_in_ready || b_in_ready) bad++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("hold_stable", 64'(bad), 64'(0));
        chk("hold_no_start", 64'(starts - s0), 64'(0));
        get_result("hold");
        send(2, 2, 1'b1, "after_hold");
        get_result("after_hold");

        // Random bursts with random multiplier latency.
        for (int bi = 0; bi < 6; bi++) begin
            len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                mul_lat = int'($urandom_range(2, 20));
                send(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                     k == len - 1, "rnd");
            end
            get_result("rnd");
        end

        // Count saturates at 255.
        mul_lat = 2;
        for (int k = 0; k < 260; k++) begin
            send(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                 k == 259, "sat");
        end
        get_result("sat");

        // Busy never rises: timeout after TIMEOUT+1 cycles in WAIT_HI; product counts as 0.
        mul_lat = 17;
        mul_dead = 1'b1;
        send(5, 5, 1'b0, "tmo");
        n = 0;
        while (!a_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        // One extra negedge for the ISSUE cycle before WAIT_HI.
        chk("tmo_latency", 64'(n), 64'(TIMEOUT + 2));
        chk("tmo_err_b", 64'(b_err), 64'(1));
        mul_dead = 1'b0;
        exp_err = 1'b1;
        send(7, -3, 1'b1, "tmo");
        get_result("tmo");
        send(4, 4, 1'b1, "sticky");
        get_result("sticky");

        // Reset during WAIT_LO with busy still high; next pair stalls in ISSUE.
        mul_lat = 20;
        send(9, 9, 1'b1, "rst5");
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!mul_busy && n < 100);
        repeat (11) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(a_out_valid | b_out_valid), 64'(0));
        chk("arst_out_acc", 64'({a_out_acc, b_out_acc}), 64'(0));
        chk("arst_err", 64'(a_err | b_err), 64'(0));
        chk("arst_misc", 64'({a_in_ready, a_mul_x, a_mul_y, a_out_count, a_out_ovf}), 64'(0));
        chk("arst_busy_kept", 64'(mul_busy), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        model_clear();
        s0 = starts;
        send(2, -3, 1'b1, "stall");
        bad = 0;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!mul_busy) break;
            if (a_mul_start || b_mul_start) bad++;
            stall++;
            @(negedge clk);
        end
        chk("stall_seen", 64'(stall > 0), 64'(1));
        chk("stall_no_start", 64'(bad), 64'(0));
        get_result("stall");
        chk("stall_one_start", 64'(starts - s0), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
